// File: rtl/fmdll_lock_detect.sv
// fmdll_lock_detect: declares DLL lock once the DCDL code stays in a narrow band
// for LOCK_CNT consecutive windows; flags loss of lock with a one-cycle pulse.
// Optional feature macro: FMDLL_LOCK_CODE_OUT_EN (drives lock_code with the window midpoint).
module fmdll_lock_detect #(
    parameter int CODE_W     = 10,
    parameter int WIN_LOG2   = 4,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [CODE_W-1:0] q,
    input  logic              restart,
    output logic              locked,
    output logic              lock_lost,
    output logic [CODE_W-1:0] lock_code
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [CODE_W-1:0] TOL_C    = CODE_W'(TOL);
    localparam logic [3:0]        LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0]        UNLOCK_C = 4'(UNLOCK_CNT);

    state_t              r_state;
    logic [WIN_LOG2-1:0] r_win;
    logic [3:0]          r_good, r_bad;
    logic [CODE_W-1:0]   r_cmin, r_cmax;

    logic [CODE_W-1:0] w_cmin_n, w_cmax_n, w_span;
    logic              w_eval, w_good;

    assign w_cmin_n = (r_win == '0 || q < r_cmin) ? q : r_cmin;
    assign w_cmax_n = (r_win == '0 || q > r_cmax) ? q : r_cmax;
    assign w_span   = w_cmax_n - w_cmin_n;
    assign w_eval   = r_win == '1;
    assign w_good   = (w_span <= TOL_C) && (w_cmin_n != '0) && (w_cmax_n != '1);

    // Window tracking and lock state machine; sel leaving closed loop beats restart beats evaluation.
    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_win     <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            r_cmin    <= '0;
            r_cmax    <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            r_cmin    <= w_cmin_n;
            r_cmax    <= w_cmax_n;
            if (sel != 2'b00) begin
                lock_lost <= r_state == LOCKED;
                r_state   <= IDLE;
                locked    <= 1'b0;
                r_win     <= '0;
                r_good    <= '0;
                r_bad     <= '0;
            end else if (restart || r_state == IDLE) begin
                r_state <= ACQUIRE;
                locked  <= 1'b0;
                r_win   <= '0;
                r_good  <= '0;
                r_bad   <= '0;
            end else begin
                r_win <= r_win + WIN_LOG2'(1);
                if (w_eval) begin
                    if (r_state == ACQUIRE) begin
                        if (!w_good)
                            r_good <= '0;
                        else if (r_good == LOCK_C - 4'd1) begin
                            r_state <= LOCKED;
                            locked  <= 1'b1;
                            r_good  <= '0;
                            r_bad   <= '0;
                        end else
                            r_good <= r_good + 4'd1;
                    end else begin
                        if (w_good)
                            r_bad <= '0;
                        else if (r_bad == UNLOCK_C - 4'd1) begin
                            r_state   <= ACQUIRE;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            r_good    <= '0;
                            r_bad     <= '0;
                        end else
                            r_bad <= r_bad + 4'd1;
                    end
                end
            end
        end
    end

`ifdef FMDLL_LOCK_CODE_OUT_EN
    logic [CODE_W:0] w_sum;
    logic            w_load;

    assign w_sum  = {1'b0, w_cmin_n} + {1'b0, w_cmax_n};
    assign w_load = (sel == 2'b00) && !restart && (r_state != IDLE) && w_eval && w_good &&
                    (r_state == LOCKED || r_good == LOCK_C - 4'd1);

    // Capture the band midpoint on lock entry and on every good window while locked.
    always_ff @(posedge clk_ext) begin
        if (!rst_n)
            lock_code <= '0;
        else if (w_load)
            lock_code <= w_sum[CODE_W:1];
    end
`else
    assign lock_code = '0;
`endif

endmodule

// File: tb/tb_fmdll_lock_detect.sv
// tb_fmdll_lock_detect: randomized scoreboard bench for fmdll_lock_detect against a window-list model.
module tb_fmdll_lock_detect;
    localparam int CW = 10, WL = 4, TOL = 2, LOCK = 4, UNLOCK = 2;
    localparam int WIN = 1 << WL, TOP = (1 << CW) - 1;

    typedef struct packed {
        logic          lk;
        logic          lost;
        logic [CW-1:0] code;
    } exp_t;

    logic          clk_ext = 1'b0, rst_n = 1'b0, restart = 1'b0;
    logic [1:0]    sel = 2'b11;
    logic [CW-1:0] q = '0;
    logic          locked, lock_lost;
    logic [CW-1:0] lock_code;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;

    int m_mode = 0, m_good = 0, m_bad = 0, m_lk = 0, m_lost = 0, m_code = 0;
    int m_win[$];

    always #5 clk_ext = ~clk_ext;

    fmdll_lock_detect #(.CODE_W(CW), .WIN_LOG2(WL), .TOL(TOL), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .sel(sel), .q(q), .restart(restart),
        .locked(locked), .lock_lost(lock_lost), .lock_code(lock_code)
    );

    function automatic void chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endfunction

    // Reference: collects each window's samples, then judges the window from its min/max.
    task automatic model(input logic [1:0] s, input int qv, input logic rs, input logic rn);
        int  mn, mx;
        bit  ok;
        m_lost = 0;
        if (!rn) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_lk = 0; m_code = 0;
            m_win.delete();
        end else if (s != 2'b00) begin
            if (m_mode == 2) m_lost = 1;
            m_mode = 0; m_lk = 0; m_good = 0; m_bad = 0;
            m_win.delete();
        end else if (rs || m_mode == 0) begin
            m_mode = 1; m_lk = 0; m_good = 0; m_bad = 0;
            m_win.delete();
        end else begin
            m_win.push_back(qv);
            if (m_win.size() == WIN) begin
                mn = TOP; mx = 0;
                foreach (m_win[i]) begin
                    mn = m_win[i] < mn ? m_win[i] : mn;
                    mx = m_win[i] > mx ? m_win[i] : mx;
                end
                m_win.delete();
                ok = (mx - mn <= TOL) && mn != 0 && mx != TOP;
                if (m_mode == 1) begin
                    m_good = ok ? m_good + 1 : 0;
                    if (m_good == LOCK) begin
                        m_mode = 2; m_lk = 1; m_bad = 0; m_good = 0;
                        m_code = (mn + mx) / 2;
                    end
                end else if (ok) begin
                    m_bad = 0;
                    m_code = (mn + mx) / 2;
                end else begin
                    m_bad++;
                    if (m_bad == UNLOCK) begin
                        m_mode = 1; m_lk = 0; m_lost = 1; m_good = 0; m_bad = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic [1:0] s, input int qv, input logic rs, input logic rn);
        exp_t e;
        @(negedge clk_ext);
        sel = s; q = qv[CW-1:0]; restart = rs; rst_n = rn;
        model(s, qv, rs, rn);
        e.lk   = m_lk != 0;
        e.lost = m_lost != 0;
`ifdef FMDLL_LOCK_CODE_OUT_EN
        e.code = CW'(m_code);
`else
        e.code = '0;
`endif
        exp_q.push_back(e);
    endtask

    // kind 0: steady base; 1: alternate base/base+d; 2: uniform random code
    task automatic seg(input int n, input int kind, input int base, input int d, input bit noisy);
        int       qv;
        logic [1:0] s;
        logic     rs, rn;
        for (int i = 0; i < n; i++) begin
            qv = kind == 0 ? base : kind == 1 ? ((i % 2) ? base + d : base) : int'($urandom_range(0, TOP));
            s = 2'b00; rs = 1'b0; rn = 1'b1;
            if (noisy) begin
                if ($urandom_range(0, 199) == 0) s = 2'($urandom_range(1, 3));
                rs = $urandom_range(0, 199) == 0;
                rn = $urandom_range(0, 399) != 0;
            end
            cyc(s, qv, rs, rn);
        end
    endtask

    // Monitor: one expected response per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_ext);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("locked", CW'(locked), CW'(e.lk));
                chk("lock_lost", CW'(lock_lost), CW'(e.lost));
                chk("lock_code", lock_code, e.code);
            end
        end
    end

    initial begin
        int k, b;
        repeat (3) cyc(2'b11, 512, 1'b0, 1'b0);
        seg(80, 0, 512, 0, 1'b0);
        seg(40, 1, 600, 100, 1'b0);
        seg(80, 0, 512, 0, 1'b0);
        cyc(2'b01, 512, 1'b0, 1'b1);
        seg(80, 0, 512, 0, 1'b0);
        cyc(2'b00, 512, 1'b1, 1'b1);
        seg(80, 1, 511, 2, 1'b0);
        seg(80, 1, 511, 3, 1'b0);
        cyc(2'b00, 0, 1'b1, 1'b1);
        seg(100, 0, 0, 0, 1'b0);
        seg(100, 0, TOP, 0, 1'b0);
        seg(80, 1, 300, 1, 1'b0);
        cyc(2'b10, 300, 1'b1, 1'b1);
        seg(80, 0, 1, 0, 1'b0);
        seg(80, 0, TOP - 1, 0, 1'b0);
        cyc(2'b00, 512, 1'b1, 1'b1);
        seg(70, 0, 512, 0, 1'b0);
        cyc(2'b00, 512, 1'b0, 1'b0);
        seg(80, 0, 700, 0, 1'b0);
        repeat (40) begin
            k = $urandom_range(0, 3);
            b = $urandom_range(1, TOP - 4);
            if (k == 3) seg($urandom_range(20, 150), 0, ($urandom_range(0, 1) != 0) ? 0 : TOP, 0, 1'b1);
            else seg($urandom_range(20, 150), k, b, $urandom_range(0, 3), 1'b1);
        end
        repeat (3) @(negedge clk_ext);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
